// File: rtl/fpcvt_pkg.sv
// Shared defaults and width helpers for the two's-complement to small-float converter.
package fpcvt_pkg;

  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned EXP_W_DEF  = 3;
  localparam int unsigned MAN_W_DEF  = 4;

  function automatic int unsigned e_max(input int unsigned exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int unsigned lz_w(input int unsigned data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/fpcvt_lzc.sv
// Priority encoder: reports whether the word is zero and the index of its highest set bit.
module fpcvt_lzc #(
  parameter int unsigned W   = 11,
  parameter int unsigned P_W = 4
) (
  input  logic [W-1:0]   i_m,
  output logic           o_zero,
  output logic [P_W-1:0] o_pos
);

  always_comb begin
    o_zero = ~|i_m;
    o_pos  = '0;
    for (int i = 0; i < W; i++) begin
      if (i_m[i]) o_pos = P_W'(i);
    end
  end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage streaming converter: sign/magnitude, normalise, round/saturate.
// All stages advance together on one enable so a stalled sink freezes the whole pipe.
module fpcvt_pipe
  import fpcvt_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned MAN_W  = MAN_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_d,
  input  logic              i_rnd_en,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_s,
  output logic [EXP_W-1:0]  o_e,
  output logic [MAN_W-1:0]  o_f,
  output logic              o_ovf
);

  localparam int unsigned M_W  = DATA_W - 1;
  localparam int unsigned LZ_W = lz_w(DATA_W);
  // Internal exponent is wide enough to see E_MAX+1 before saturation.
  localparam int unsigned EI_W = (LZ_W > EXP_W) ? LZ_W + 1 : EXP_W + 1;
  localparam int unsigned EMAX = e_max(EXP_W);
  localparam int unsigned FS_W = MAN_W + 1;

  logic w_en;
  assign w_en       = ~o_out_valid | i_out_ready;
  assign o_in_ready = w_en;

  // Stage 1: sign/magnitude
  logic           w1_min;
  logic [M_W-1:0] w1_m;
  assign w1_min = (i_d == {1'b1, {M_W{1'b0}}});
  assign w1_m   = w1_min ? '1 :
                  (i_d[DATA_W-1] ? (~i_d[M_W-1:0] + M_W'(1)) : i_d[M_W-1:0]);

  logic           r1_v, r1_s, r1_ovf, r1_rnd;
  logic [M_W-1:0] r1_m;

  // Stage 2: normalise
  logic            w_zero;
  logic [LZ_W-1:0] w_pos, w_sh;
  logic [EI_W-1:0] w2_e;
  logic [MAN_W-1:0] w2_f;
  logic            w2_r;

  fpcvt_lzc #(
    .W   (M_W),
    .P_W (LZ_W)
  ) u_lzc (
    .i_m    (r1_m),
    .o_zero (w_zero),
    .o_pos  (w_pos)
  );

  always_comb begin
    w_sh = w_pos - LZ_W'(MAN_W);
    w2_e = '0;
    w2_r = 1'b0;
    w2_f = r1_m[MAN_W-1:0];
    if (!w_zero && (w_pos >= LZ_W'(MAN_W))) begin
      w2_f = r1_m[w_pos -: MAN_W];
      w2_r = r1_m[w_sh];
      w2_e = EI_W'(w_sh) + EI_W'(1);
    end
  end

  logic             r2_v, r2_s, r2_ovf, r2_rnd, r2_r;
  logic [EI_W-1:0]  r2_e;
  logic [MAN_W-1:0] r2_f;

  // Stage 3: round and saturate
  logic [FS_W-1:0]  w_fsum;
  logic [EI_W-1:0]  w3_e;
  logic [MAN_W-1:0] w3_f;
  logic             w3_ovf;
  logic [EXP_W-1:0] w3_eo;
  logic [MAN_W-1:0] w3_fo;

  always_comb begin
    w_fsum = {1'b0, r2_f} + FS_W'(r2_rnd & r2_r);
    w3_e   = r2_e;
    w3_f   = w_fsum[MAN_W-1:0];
    if (w_fsum[MAN_W]) begin
      w3_f = MAN_W'(1) << (MAN_W - 1);
      w3_e = r2_e + EI_W'(1);
    end
    w3_ovf = r2_ovf | (w3_e > EI_W'(EMAX));
    w3_eo  = w3_e[EXP_W-1:0];
    w3_fo  = w3_f;
    if (w3_ovf) begin
      w3_eo = EXP_W'(EMAX);
      w3_fo = '1;
    end
  end

  logic             r_out_valid, r_s, r_ovf;
  logic [EXP_W-1:0] r_e;
  logic [MAN_W-1:0] r_f;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r1_v        <= 1'b0;
      r1_s        <= 1'b0;
      r1_ovf      <= 1'b0;
      r1_rnd      <= 1'b0;
      r1_m        <= '0;
      r2_v        <= 1'b0;
      r2_s        <= 1'b0;
      r2_ovf      <= 1'b0;
      r2_rnd      <= 1'b0;
      r2_r        <= 1'b0;
      r2_e        <= '0;
      r2_f        <= '0;
      r_out_valid <= 1'b0;
      r_s         <= 1'b0;
      r_ovf       <= 1'b0;
      r_e         <= '0;
      r_f         <= '0;
    end else if (w_en) begin
      r1_v        <= i_in_valid;
      r1_s        <= i_d[DATA_W-1];
      r1_ovf      <= w1_min;
      r1_rnd      <= i_rnd_en;
      r1_m        <= w1_m;
      r2_v        <= r1_v;
      r2_s        <= r1_s;
      r2_ovf      <= r1_ovf;
      r2_rnd      <= r1_rnd;
      r2_r        <= w2_r;
      r2_e        <= w2_e;
      r2_f        <= w2_f;
      r_out_valid <= r2_v;
      r_s         <= r2_s;
      r_ovf       <= w3_ovf;
      r_e         <= w3_eo;
      r_f         <= w3_fo;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_s         = r_s;
  assign o_e         = r_e;
  assign o_f         = r_f;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Randomised and directed bench for fpcvt_pipe against an arithmetic reference model.
module tb_fpcvt_pipe;

  typedef struct packed {
    logic       ovf;
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
  } res_t;

  typedef struct {
    logic [11:0] d;
    logic        rnd;
    res_t        exp_r;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [11:0] i_d = '0;
  logic        i_rnd_en = 1'b0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic        o_s;
  logic [2:0]  o_e;
  logic [3:0]  o_f;
  logic        o_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  res_t q[$];
  bit   rnd_done;

  fpcvt_pipe u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_d         (i_d),
    .i_rnd_en    (i_rnd_en),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_s         (o_s),
    .o_e         (o_e),
    .o_f         (o_f),
    .o_ovf       (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  // Value = (-1)^S * F * 2^E, F scaled by plain integer division with optional half-up rounding.
  function automatic res_t model(input logic [11:0] d, input logic rnd);
    res_t r;
    int v, mag, e, f;
    r = '0;
    v = int'($signed(d));
    r.s = (v < 0);
    mag = (v < 0) ? -v : v;
    if (v == -2048) begin
      r.ovf = 1'b1; r.e = 3'd7; r.f = 4'd15;
      return r;
    end
    e = 0;
    while ((mag >> e) >= 16) e++;
    if (e > 0 && rnd) f = (mag + (1 << (e - 1))) >> e;
    else              f = mag >> e;
    if (f == 16) begin f = 8; e++; end
    if (e > 7) begin
      r.ovf = 1'b1; r.e = 3'd7; r.f = 4'd15;
    end else begin
      r.e = 3'(e); r.f = 4'(f);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t dut_out();
    res_t r;
    r.ovf = o_ovf; r.s = o_s; r.e = o_e; r.f = o_f;
    return r;
  endfunction

  // Compare process: scoreboard on transfers, in_ready rule and hold-while-stalled.
  bit   stalled = 1'b0;
  res_t held;
  always @(negedge i_clk) begin
    if (stalled) begin
      chk("stall_valid_held", int'(o_out_valid), 1);
      chk("stall_data_held", int'(dut_out()), int'(held));
    end
    stalled = 1'b0;
    if (i_rst) begin
      q.delete();
    end else begin
      chk("in_ready_rule", int'(o_in_ready), int'(!o_out_valid || i_out_ready));
      if (o_out_valid && i_out_ready) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else chk("output_data", int'(dut_out()), int'(q.pop_front()));
      end else if (o_out_valid) begin
        stalled = 1'b1;
        held    = dut_out();
      end
      if (i_in_valid && o_in_ready) q.push_back(model(i_d, i_rnd_en));
    end
  end

  task automatic send(input logic [11:0] d, input logic rnd);
    int guard;
    guard = 0;
    i_in_valid = 1'b1; i_d = d; i_rnd_en = rnd;
    @(negedge i_clk);
    while (!o_in_ready && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 0, 1);
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
  endtask

  // Assumes an empty pipe and out_ready=1; checks 3-clock latency and the result.
  task automatic lat_check(input logic [11:0] d, input logic rnd);
    i_in_valid = 1'b1; i_d = d; i_rnd_en = rnd;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    @(negedge i_clk); chk("lat_clk1_invalid", int'(o_out_valid), 0);
    @(negedge i_clk); chk("lat_clk2_invalid", int'(o_out_valid), 0);
    @(negedge i_clk); chk("lat_clk3_valid", int'(o_out_valid), 1);
    chk("lat_data", int'(dut_out()), int'(model(d, rnd)));
    @(posedge i_clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int guard;
    tbl[0] = '{12'h000, 1'b0, res_t'({1'b0, 1'b0, 3'd0, 4'd0})};
    tbl[1] = '{12'h07D, 1'b1, res_t'({1'b0, 1'b0, 3'd4, 4'd8})};
    tbl[2] = '{12'h07D, 1'b0, res_t'({1'b0, 1'b0, 3'd3, 4'd15})};
    tbl[3] = '{12'hF83, 1'b1, res_t'({1'b0, 1'b1, 3'd4, 4'd8})};
    tbl[4] = '{12'hFFF, 1'b0, res_t'({1'b0, 1'b1, 3'd0, 4'd1})};
    tbl[5] = '{12'h800, 1'b0, res_t'({1'b1, 1'b1, 3'd7, 4'd15})};
    tbl[6] = '{12'h7FF, 1'b1, res_t'({1'b1, 1'b0, 3'd7, 4'd15})};
    tbl[7] = '{12'h7FF, 1'b0, res_t'({1'b0, 1'b0, 3'd7, 4'd15})};
    tbl[8] = '{12'h010, 1'b1, res_t'({1'b0, 1'b0, 3'd1, 4'd8})};

    foreach (tbl[i]) chk("model_pin", int'(model(tbl[i].d, tbl[i].rnd)), int'(tbl[i].exp_r));

    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("reset_out_valid", int'(o_out_valid), 0);
    chk("reset_outputs", int'(dut_out()), 0);
    chk("reset_in_ready", int'(o_in_ready), 1);

    @(posedge i_clk); #1;
    lat_check(12'h000, 1'b0);
    lat_check(12'h07D, 1'b1);
    foreach (tbl[i]) send(tbl[i].d, tbl[i].rnd);

    // Stream with a 4-clock sink stall in the middle.
    repeat (5) @(posedge i_clk);
    #1;
    fork
      for (int i = 0; i < 8; i++) send(12'(i * 300 + 17), i[0]);
      begin
        repeat (3) @(posedge i_clk);
        #1 i_out_ready = 1'b0;
        repeat (4) @(posedge i_clk);
        #1 i_out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge i_clk);
    #1;
    chk("stream_drained", q.size(), 0);

    // Reset with two samples in flight.
    send(12'h123, 1'b1);
    send(12'hABC, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_flush_valid", int'(o_out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("rst_no_stale", int'(o_out_valid), 0);
    end
    @(posedge i_clk); #1;
    lat_check(12'h456, 1'b1);

    // Random traffic with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge i_clk); #1;
          end
          send(12'($urandom), 1'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge i_clk); #1;
          i_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(posedge i_clk); #1;
      guard++;
    end
    chk("final_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
